// File: rtl/common_data_bus.sv
// common_data_bus
//   Collects results from three ALUs into per-ALU FIFOs and broadcasts one
//   result per cycle on the common data bus, using round-robin arbitration.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   fu_valid/result/destReg/ROBNum_ALUk   result presented by ALU k
//   wb_ready_ALUk                 FIFO k has room (registered count only)
//   cdb_stall                     consumer cannot take a broadcast
//   cdb_valid/data/destReg/ROBNum/aluNum  registered broadcast
//   overflow_err                  sticky: a result arrived at a full FIFO
module common_data_bus #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        fu_valid_ALU0,
   input  logic [31:0] fu_result_ALU0,
   input  logic [5:0]  fu_destReg_ALU0,
   input  logic [15:0] fu_ROBNum_ALU0,
   input  logic        fu_valid_ALU1,
   input  logic [31:0] fu_result_ALU1,
   input  logic [5:0]  fu_destReg_ALU1,
   input  logic [15:0] fu_ROBNum_ALU1,
   input  logic        fu_valid_ALU2,
   input  logic [31:0] fu_result_ALU2,
   input  logic [5:0]  fu_destReg_ALU2,
   input  logic [15:0] fu_ROBNum_ALU2,
   output logic        wb_ready_ALU0,
   output logic        wb_ready_ALU1,
   output logic        wb_ready_ALU2,
   input  logic        cdb_stall,
   output logic        cdb_valid,
   output logic [31:0] cdb_data,
   output logic [5:0]  cdb_destReg,
   output logic [15:0] cdb_ROBNum,
   output logic [1:0]  cdb_aluNum,
   output logic        overflow_err
);

   // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally.
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  dest;
      logic [15:0] rob;
   } entry_t;

   entry_t        in_ent [3];
   logic [2:0]    in_vld;
   entry_t        mem_q  [3][FIFO_DEPTH];
   logic [PW-1:0] wptr_q [3];
   logic [PW-1:0] rptr_q [3];
   logic [PW:0]   cnt_q  [3];
   logic [PW:0]   cnt_d  [3];
   logic [2:0]    rdy, push, pop, nonempty;
   logic [1:0]    rr_q, rr_d;

   logic          grant_vld;
   logic [1:0]    grant_idx;
   logic [2:0]    cand_sum;
   logic [1:0]    cand;
   entry_t        head;

   logic          valid_q, valid_d;
   entry_t        out_q, out_d;
   logic [1:0]    alu_q, alu_d;
   logic          ovf_q;

   assign in_vld    = {fu_valid_ALU2, fu_valid_ALU1, fu_valid_ALU0};
   assign in_ent[0] = '{data: fu_result_ALU0, dest: fu_destReg_ALU0, rob: fu_ROBNum_ALU0};
   assign in_ent[1] = '{data: fu_result_ALU1, dest: fu_destReg_ALU1, rob: fu_ROBNum_ALU1};
   assign in_ent[2] = '{data: fu_result_ALU2, dest: fu_destReg_ALU2, rob: fu_ROBNum_ALU2};

   always_comb begin
      rdy      = '0;
      push     = '0;
      nonempty = '0;
      for (int k = 0; k < 3; k++) begin
         rdy[k]      = (cnt_q[k] != FULL_CNT);
         push[k]     = in_vld[k] & rdy[k];
         nonempty[k] = (cnt_q[k] != '0);
      end
   end

   // Scan from lowest to highest priority so the highest-priority hit wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      cand_sum  = '0;
      cand      = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         cand_sum = {1'b0, rr_q} + 3'(i);
         cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
         if (nonempty[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      case (grant_idx)
         2'd0:    head = mem_q[0][rptr_q[0]];
         2'd1:    head = mem_q[1][rptr_q[1]];
         default: head = mem_q[2][rptr_q[2]];
      endcase
   end

   always_comb begin
      pop = '0;
      for (int k = 0; k < 3; k++) begin
         pop[k] = grant_vld & ~cdb_stall & (grant_idx == 2'(k));
         if (push[k] && !pop[k]) begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
         end else if (!push[k] && pop[k]) begin
            cnt_d[k] = cnt_q[k] - CNT_ONE;
         end else begin
            cnt_d[k] = cnt_q[k];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      out_d   = out_q;
      alu_d   = alu_q;
      rr_d    = rr_q;
      if (!cdb_stall) begin
         if (grant_vld) begin
            valid_d = 1'b1;
            out_d   = head;
            alu_d   = grant_idx;
            rr_d    = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 3; k++) begin
            wptr_q[k] <= '0;
            rptr_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
         rr_q    <= 2'd0;
         valid_q <= 1'b0;
         out_q   <= '0;
         alu_q   <= 2'd0;
         ovf_q   <= 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (push[k]) wptr_q[k] <= wptr_q[k] + PTR_ONE;
            if (pop[k])  rptr_q[k] <= rptr_q[k] + PTR_ONE;
            cnt_q[k] <= cnt_d[k];
         end
         rr_q    <= rr_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         alu_q   <= alu_d;
         ovf_q   <= ovf_q | (|(in_vld & ~rdy));
      end
   end

   // Storage needs no reset: entries are only visible through the counts.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (push[k]) mem_q[k][wptr_q[k]] <= in_ent[k];
      end
   end

   assign wb_ready_ALU0 = rdy[0];
   assign wb_ready_ALU1 = rdy[1];
   assign wb_ready_ALU2 = rdy[2];
   assign cdb_valid     = valid_q;
   assign cdb_data      = out_q.data;
   assign cdb_destReg   = out_q.dest;
   assign cdb_ROBNum    = out_q.rob;
   assign cdb_aluNum    = alu_q;
   assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_common_data_bus.sv
// Testbench for common_data_bus: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model.
module tb_common_data_bus;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [2:0]  vld = '0;
   logic [31:0] res  [3];
   logic [5:0]  dst  [3];
   logic [15:0] rob  [3];
   logic        stall = 1'b0;
   logic        wb_ready_ALU0, wb_ready_ALU1, wb_ready_ALU2;
   logic        cdb_valid, overflow_err;
   logic [31:0] cdb_data;
   logic [5:0]  cdb_destReg;
   logic [15:0] cdb_ROBNum;
   logic [1:0]  cdb_aluNum;

   int tests = 0;
   int fails = 0;

   common_data_bus #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .fu_valid_ALU0(vld[0]), .fu_result_ALU0(res[0]), .fu_destReg_ALU0(dst[0]), .fu_ROBNum_ALU0(rob[0]),
      .fu_valid_ALU1(vld[1]), .fu_result_ALU1(res[1]), .fu_destReg_ALU1(dst[1]), .fu_ROBNum_ALU1(rob[1]),
      .fu_valid_ALU2(vld[2]), .fu_result_ALU2(res[2]), .fu_destReg_ALU2(dst[2]), .fu_ROBNum_ALU2(rob[2]),
      .wb_ready_ALU0(wb_ready_ALU0), .wb_ready_ALU1(wb_ready_ALU1), .wb_ready_ALU2(wb_ready_ALU2),
      .cdb_stall(stall), .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_destReg(cdb_destReg),
      .cdb_ROBNum(cdb_ROBNum), .cdb_aluNum(cdb_aluNum), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic [5:0]  r;
      logic [15:0] rob;
      logic [1:0]  a;
      logic [2:0]  rdy;
      logic        ovf;
   } exp_t;

   // Reference model: one queue of pending results per ALU, a round-robin
   // pointer, and the currently broadcast value.
   logic [53:0] mq [3][$];
   int          m_rr;
   exp_t        m_cur;
   logic        m_ovf;
   exp_t        expq [$];

   function automatic void model_clear();
      for (int k = 0; k < 3; k++) mq[k].delete();
      m_rr  = 0;
      m_ovf = 1'b0;
      m_cur = '{v: 1'b0, d: '0, r: '0, rob: '0, a: '0, rdy: 3'b111, ovf: 1'b0};
      expq.delete();
   endfunction

   always @(negedge rstn) model_clear();

   always @(posedge clk) begin
      if (!rstn) begin
         model_clear();
      end else begin
         exp_t        e;
         bit   [2:0]  room;
         e = m_cur;
         for (int k = 0; k < 3; k++) room[k] = (mq[k].size() < DEPTH);
         if (!stall) begin
            int g;
            g = -1;
            for (int i = 0; i < 3; i++) begin
               if (g < 0 && mq[(m_rr + i) % 3].size() > 0) g = (m_rr + i) % 3;
            end
            if (g >= 0) begin
               logic [53:0] h;
               h     = mq[g].pop_front();
               e.v   = 1'b1;
               e.d   = h[53:22];
               e.r   = h[21:16];
               e.rob = h[15:0];
               e.a   = 2'(g);
               m_rr  = (g + 1) % 3;
            end else begin
               e.v = 1'b0;
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (vld[k]) begin
               if (room[k]) mq[k].push_back({res[k], dst[k], rob[k]});
               else         m_ovf = 1'b1;
            end
         end
         for (int k = 0; k < 3; k++) e.rdy[k] = (mq[k].size() < DEPTH);
         e.ovf = m_ovf;
         m_cur = e;
         expq.push_back(e);
      end
   end

   // Monitor: every cycle the DUT outputs are compared with the model's
   // prediction for that edge.
   always @(negedge clk) begin
      if (rstn && expq.size() > 0) begin
         exp_t e, act;
         e   = expq.pop_front();
         act = '{v: cdb_valid, d: cdb_data, r: cdb_destReg, rob: cdb_ROBNum, a: cdb_aluNum,
                 rdy: {wb_ready_ALU2, wb_ready_ALU1, wb_ready_ALU0}, ovf: overflow_err};
         tests++;
         if (act !== e) begin
            fails++;
            $display("FAIL cdb_scoreboard t=%0t: got v=%0b d=%h r=%0d rob=%0d alu=%0d rdy=%b ovf=%0b, expected v=%0b d=%h r=%0d rob=%0d alu=%0d rdy=%b ovf=%0b",
                     $time, act.v, act.d, act.r, act.rob, act.a, act.rdy, act.ovf,
                     e.v, e.d, e.r, e.rob, e.a, e.rdy, e.ovf);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic rand_data(input int k);
      res[k] = $urandom;
      dst[k] = 6'($urandom);
      rob[k] = 16'($urandom);
   endtask

   initial begin
      int n;
      logic [31:0] held;
      for (int k = 0; k < 3; k++) rand_data(k);

      // Reset state
      repeat (2) step();
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_data", 64'(cdb_data), 64'd0);
      chk("rst_dest_rob_alu", {cdb_destReg, cdb_ROBNum, cdb_aluNum}, 64'd0);
      chk("rst_ready", 64'({wb_ready_ALU2, wb_ready_ALU1, wb_ready_ALU0}), 64'h7);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      rstn = 1'b1;
      step();

      // Single result from ALU1: visible after the edge following the push
      vld = 3'b010; res[1] = 32'h0000_00AB; dst[1] = 6'd12; rob[1] = 16'd5;
      step();
      vld = '0;
      step();
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_data", 64'(cdb_data), 64'hAB);
      chk("single_dest", 64'(cdb_destReg), 64'd12);
      chk("single_rob", 64'(cdb_ROBNum), 64'd5);
      chk("single_alu", 64'(cdb_aluNum), 64'd1);
      step();
      chk("single_done", 64'(cdb_valid), 64'd0);

      // Round robin from rr=0
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) rand_data(k);
      vld = 3'b111;
      step();
      vld = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rr_order_valid", 64'(cdb_valid), 64'd1);
         chk("rr_order_alu", 64'(cdb_aluNum), 64'(k));
      end
      step();
      chk("rr_idle", 64'(cdb_valid), 64'd0);
      rand_data(0); rand_data(1);
      vld = 3'b011;
      step();
      vld = '0;
      step();
      chk("rr_wrapped", 64'(cdb_aluNum), 64'd0);
      repeat (2) step();

      // Fill ALU0 under stall, overflow on the fifth push
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_data(0);
         vld = 3'b001;
         step();
         if (i == 3) chk("full_ready0", 64'(wb_ready_ALU0), 64'd0);
      end
      vld = '0;
      chk("overflow_set", 64'(overflow_err), 64'd1);
      stall = 1'b0;
      n = 0;
      repeat (6) begin
         step();
         if (cdb_valid) n++;
      end
      chk("full_drain_count", 64'(n), 64'd4);

      // Stall hold on an active broadcast
      rand_data(2);
      held = res[2];
      vld = 3'b100;
      step();
      vld = '0;
      step();
      stall = 1'b1;
      rand_data(0);
      vld = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         vld = '0;
         chk("stall_valid", 64'(cdb_valid), 64'd1);
         chk("stall_data", 64'(cdb_data), 64'(held));
         chk("stall_alu", 64'(cdb_aluNum), 64'd2);
      end
      stall = 1'b0;
      repeat (6) step();

      // Push while full and popping: no push that cycle, then ready again
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_data(2);
         vld = 3'b100;
         step();
      end
      chk("pp_full_ready2", 64'(wb_ready_ALU2), 64'd0);
      stall = 1'b0;
      rand_data(2);
      step();
      chk("pp_ready2_after_pop", 64'(wb_ready_ALU2), 64'd1);
      rand_data(2);
      step();
      vld = '0;
      repeat (8) step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < 3; k++) begin
            rand_data(k);
            vld[k] = ($urandom_range(0, 2) == 0);
         end
         step();
      end
      vld = '0;
      stall = 1'b0;
      repeat (10) step();

      // Reset mid-operation with buffered entries
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 3; k++) rand_data(k);
         vld = 3'b111;
         step();
      end
      vld = '0;
      stall = 1'b0;
      step();
      chk("pre_reset_valid", 64'(cdb_valid), 64'd1);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_valid", 64'(cdb_valid), 64'd0);
      chk("async_rst_ready", 64'({wb_ready_ALU2, wb_ready_ALU1, wb_ready_ALU0}), 64'h7);
      chk("async_rst_data", 64'(cdb_data), 64'd0);
      step();
      rstn = 1'b1;
      n = 0;
      repeat (5) begin
         step();
         if (cdb_valid) n++;
      end
      chk("post_rst_no_bcast", 64'(n), 64'd0);
      chk("post_rst_ready", 64'({wb_ready_ALU2, wb_ready_ALU1, wb_ready_ALU0}), 64'h7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/common_data_bus.md
COMMON_DATA_BUS -- requirements
Module: common_data_bus

Interface
REQ-001 SHALL use a single clock; reset is asynchronous and active-low; ports are named clk and rstn.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the result-buffer entries per ALU (power of two).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 fu_valid_ALUk (k=0,1,2)  input  1  ALU k presents a result this cycle.
REQ-006 fu_result_ALUk  input  32  result data.
REQ-007 fu_destReg_ALUk  input  6  physical destination register.
REQ-008 fu_ROBNum_ALUk  input  16  ROB tag of the instruction.
REQ-009 wb_ready_ALUk  output  1  buffer k can accept a result; equals (count_k != FIFO_DEPTH).
REQ-010 cdb_stall  input  1  consumer (ROB/issue queue) cannot take a broadcast this cycle.
REQ-011 cdb_valid  output  1  broadcast valid.
REQ-012 cdb_data  output  32  broadcast result.
REQ-013 cdb_destReg  output  6  broadcast physical register (wakeup tag).
REQ-014 cdb_ROBNum  output  16  broadcast ROB tag.
REQ-015 cdb_aluNum  output  2  source ALU of the broadcast (0..2).
REQ-016 overflow_err  output  1  sticky flag: a result was presented while its buffer was full.

Function
REQ-017 SHALL keep one FIFO per ALU; each entry holds {result, destReg, ROBNum}; read/write pointers are log2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0.
REQ-018 SHALL push on ALU k at a rising edge iff fu_valid_ALUk and wb_ready_ALUk, both sampled before that edge.
REQ-019 wb_ready_ALUk SHALL depend only on the registered count; a full FIFO being popped in the same cycle still reports not-ready.
REQ-020 fu_valid_ALUk while wb_ready_ALUk=0 SHALL drop the result, leave the FIFO unchanged and set overflow_err, which stays 1 until reset.
REQ-021 SHALL arbitrate combinationally each cycle among non-empty FIFOs using round-robin pointer rr in {0,1,2}; priority order is rr, rr+1, rr+2 (mod 3).
REQ-022 When cdb_stall=0 and a grant exists to k, at the next edge the block SHALL:
- pop FIFO k;
- register its head onto cdb_data/cdb_destReg/cdb_ROBNum;
- set cdb_aluNum=k and cdb_valid=1;
- set rr=(k+1) mod 3.
REQ-023 When cdb_stall=0 and all FIFOs are empty, cdb_valid SHALL be 0 at the next edge, the data outputs SHALL hold, and rr SHALL be unchanged.
REQ-024 When cdb_stall=1, the block SHALL pop nothing, leave all cdb_* outputs and rr unchanged, and continue accepting pushes.
REQ-025 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged and preserve FIFO order.
REQ-026 Latency: a result pushed at edge N into an empty, uncontended FIFO SHALL appear on the CDB after edge N+1; the block SHALL never bypass directly from input to output.
REQ-027 Broadcast throughput SHALL be at most one per cycle; results from the same ALU SHALL be broadcast in arrival order.
REQ-028 Each count SHALL range 0..FIFO_DEPTH and never underflow or overflow.

Reset
REQ-029 While rstn=0, and immediately on its assertion, the block SHALL:
- clear all FIFO pointers and counts;
- set rr=0;
- set cdb_valid=0, cdb_data=0, cdb_destReg=0, cdb_ROBNum=0, cdb_aluNum=0, overflow_err=0.
wb_ready_ALU0..2 are therefore 1.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results; the first cycle after deassertion behaves as after power-up.

Verification
REQ-031 Single result: ALU1 pushes {data=0x0000_00AB, dest=6'd12, ROB=16'd5} at edge 1 → after edge 2: cdb_valid=1, cdb_data=0xAB, cdb_destReg=12, cdb_ROBNum=5, cdb_aluNum=1; after edge 3: cdb_valid=0.
REQ-032 Round-robin: all three ALUs push in the same cycle with rr=0 → broadcasts on the next three cycles in cdb_aluNum order 0,1,2; then rr=0.
REQ-033 Full/overflow: cdb_stall=1, ALU0 pushes 5 consecutive results → wb_ready_ALU0=0 after the 4th push; the 5th is dropped and overflow_err=1. Release stall → exactly 4 broadcasts in push order.
REQ-034 Stall hold: a broadcast is on the CDB, cdb_stall=1 for 3 cycles → all cdb_* outputs remain constant and FIFO counts do not decrease.
REQ-035 Push+pop at full: ALU2 FIFO full, stall released, fu_valid_ALU2=1 → no push that cycle, count goes 4→3, then wb_ready_ALU2=1.
REQ-036 Reset mid-operation: 2 entries buffered in each FIFO, rstn pulsed low between edges → cdb_valid=0 immediately, no further broadcasts, wb_ready_ALU0..2=1.
